bounce_sprite_engine: RTL and testbench

Parametrised bouncing-sprite animator for the VGA start screen. It holds NUM_BALLS square sprites inside a configurable rectangular box and advances every sprite once per video frame, with wall reflection and clamping. It also supports per-frame speed selection, pause, and an optional wall-hit counter. It sits between the VGA timing generator (which supplies x, y) and the colour mux (which consumes b_draw, b_square).

---
 rtl/bounce_pkg.sv | 20 ++
 rtl/bounce_axis.sv | 49 ++++
 rtl/bounce_sprite_engine.sv | 148 ++++++++++++++
 tb/tb_bounce_sprite_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing-sprite animator.
package bounce_pkg;

    localparam int SPR_CORDW = 10;
    localparam int HIT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    typedef struct packed {
        logic [SPR_CORDW-1:0] bx;
        logic [SPR_CORDW-1:0] by;
        logic                 dx;
        logic                 dy;
    } sprite_t;

endpackage

// File: rtl/bounce_axis.sv
// Single-axis sprite step with wall reflection and clamping to [lo, hi-size].
// Purely combinational: zero latency, no flow control.
module bounce_axis #(
    parameter int W = 10
) (
    input  logic [W-1:0] pos_i,
    input  logic         dir_i,
    input  logic [3:0]   step_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] size_i,
    output logic [W-1:0] npos_o,
    output logic         ndir_o,
    output logic         hit_o
);

    // One extra bit so pos+step+size never wraps near the top of the coordinate range.
    logic [W:0] pos_e, step_e, lo_e, hi_e, size_e;

    assign pos_e  = {1'b0, pos_i};
    assign step_e = (W+1)'(step_i);
    assign lo_e   = {1'b0, lo_i};
    assign hi_e   = {1'b0, hi_i};
    assign size_e = {1'b0, size_i};

    always_comb begin
        npos_o = pos_i;
        ndir_o = dir_i;
        hit_o  = 1'b0;
        if (!dir_i) begin
            if (pos_e + step_e + size_e > hi_e) begin
                npos_o = W'(hi_e - size_e);
                ndir_o = 1'b1;
                hit_o  = 1'b1;
            end else begin
                npos_o = W'(pos_e + step_e);
            end
        end else begin
            if (pos_e < lo_e + step_e) begin
                npos_o = lo_i;
                ndir_o = 1'b0;
                hit_o  = 1'b1;
            end else begin
                npos_o = W'(pos_e - step_e);
            end
        end
    end

endmodule

// File: rtl/bounce_sprite_engine.sv
// Bouncing-sprite animator: one sprite updated per cycle after the frame tick, frame_done at tick+1+NUM_BALLS.
// Draw outputs are combinational; no backpressure. BOUNCE_COUNT_EN adds the saturating hit_cnt port.
module bounce_sprite_engine
    import bounce_pkg::*;
#(
    parameter int CORDW     = 10,
    parameter int NUM_BALLS = 2,
    parameter int B_SIZE    = 16,
    parameter int BOX_X0    = 220,
    parameter int BOX_X1    = 420,
    parameter int BOX_Y0    = 190,
    parameter int BOX_Y1    = 290,
    parameter int ANIM_X    = 0,
    parameter int ANIM_Y    = 480
) (
    input  logic                 vgaclk,
    input  logic                 rst_n,
    input  logic [CORDW-1:0]     x,
    input  logic [CORDW-1:0]     y,
    input  logic                 pause,
    input  logic [3:0]           sp_x,
    input  logic [3:0]           sp_y,
`ifdef BOUNCE_COUNT_EN
    output logic [HIT_W-1:0]     hit_cnt,
`endif
    output logic [NUM_BALLS-1:0] b_draw,
    output logic                 b_square,
    output logic                 frame_done
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_BALLS - 1);
    localparam logic [CORDW-1:0] X0     = CORDW'(BOX_X0);
    localparam logic [CORDW-1:0] X1     = CORDW'(BOX_X1);
    localparam logic [CORDW-1:0] Y0     = CORDW'(BOX_Y0);
    localparam logic [CORDW-1:0] Y1     = CORDW'(BOX_Y1);
    localparam logic [CORDW-1:0] SIZE   = CORDW'(B_SIZE);
    localparam logic [CORDW:0]   SIZE_E = (CORDW+1)'(B_SIZE);

    if (CORDW != SPR_CORDW || NUM_BALLS < 1 || NUM_BALLS > 8 ||
        BOX_X0 + NUM_BALLS * B_SIZE > BOX_X1 ||
        BOX_Y0 + (NUM_BALLS - 1) * (B_SIZE / 2) + B_SIZE > BOX_Y1) begin : g_bad_params
        $fatal(1, "bounce_sprite_engine: parameters place sprites outside the box");
    end

    state_t          state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]      spx_q, spx_d, spy_q, spy_d;
    sprite_t         spr_q [NUM_BALLS];
    sprite_t         spr_d [NUM_BALLS];
    sprite_t         cur;
    logic [CORDW-1:0] nbx, nby;
    logic            ndx, ndy, hit_x, hit_y, tick;

    assign tick = (x == CORDW'(ANIM_X)) && (y == CORDW'(ANIM_Y)) && !pause;
    assign cur  = spr_q[idx_q];

    bounce_axis #(.W(CORDW)) u_axis_x (
        .pos_i(cur.bx), .dir_i(cur.dx), .step_i(spx_q), .lo_i(X0), .hi_i(X1), .size_i(SIZE),
        .npos_o(nbx), .ndir_o(ndx), .hit_o(hit_x)
    );

    bounce_axis #(.W(CORDW)) u_axis_y (
        .pos_i(cur.by), .dir_i(cur.dy), .step_i(spy_q), .lo_i(Y0), .hi_i(Y1), .size_i(SIZE),
        .npos_o(nby), .ndir_o(ndy), .hit_o(hit_y)
    );

    always_ff @(posedge vgaclk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = UPDATE;
            UPDATE:  if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state_q == DONE);
        b_square   = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
        b_draw     = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            b_draw[i] = (x >= spr_q[i].bx) && ({1'b0, x} < {1'b0, spr_q[i].bx} + SIZE_E) &&
                        (y >= spr_q[i].by) && ({1'b0, y} < {1'b0, spr_q[i].by} + SIZE_E);
        end
    end

    always_comb begin
        spr_d = spr_q;
        idx_d = idx_q;
        spx_d = spx_q;
        spy_d = spy_q;
        if (state_q == IDLE && tick) begin
            spx_d = sp_x;
            spy_d = sp_y;
            idx_d = '0;
        end
        if (state_q == UPDATE) begin
            // A direction only changes on a wall hit; the hit flag gates it.
            spr_d[idx_q] = '{bx: nbx, by: nby,
                             dx: hit_x ? ndx : cur.dx,
                             dy: hit_y ? ndy : cur.dy};
            if (idx_q != LAST) idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge vgaclk) begin
        if (!rst_n) begin
            idx_q <= '0;
            spx_q <= 4'd1;
            spy_q <= 4'd1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                spr_q[i].bx <= SPR_CORDW'(BOX_X0 + i * B_SIZE);
                spr_q[i].by <= SPR_CORDW'(BOX_Y0 + i * (B_SIZE / 2));
                spr_q[i].dx <= 1'b0;
                spr_q[i].dy <= 1'b0;
            end
        end else begin
            idx_q <= idx_d;
            spx_q <= spx_d;
            spy_q <= spy_d;
            spr_q <= spr_d;
        end
    end

`ifdef BOUNCE_COUNT_EN
    logic [HIT_W-1:0] hit_q, hit_d;

    // A corner contact is one hit, and the counter sticks at all-ones.
    always_comb begin
        hit_d = hit_q;
        if (state_q == UPDATE && (hit_x || hit_y) && hit_q != '1) hit_d = hit_q + 1'b1;
    end

    always_ff @(posedge vgaclk) begin
        if (!rst_n) hit_q <= '0;
        else        hit_q <= hit_d;
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_bounce_sprite_engine.sv
// Directed bench for bounce_sprite_engine with default parameters (2 sprites, 16px, box 220..420 x 190..290).
module tb_bounce_sprite_engine;

    logic       vgaclk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       pause;
    logic [3:0] sp_x, sp_y;
    logic [1:0] b_draw;
    logic       b_square, frame_done;
`ifdef BOUNCE_COUNT_EN
    logic [15:0] hit_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 vgaclk = ~vgaclk;

    bounce_sprite_engine dut (
        .vgaclk(vgaclk), .rst_n(rst_n), .x(x), .y(y), .pause(pause),
        .sp_x(sp_x), .sp_y(sp_y),
`ifdef BOUNCE_COUNT_EN
        .hit_cnt(hit_cnt),
`endif
        .b_draw(b_draw), .b_square(b_square), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic probe(input string tag, input int i, input int px, input int py, input int want);
        x = 10'(px);
        y = 10'(py);
        #1;
        chk(tag, int'(b_draw[i]), want);
    endtask

    // Pins sprite i's top-left corner to (ex, ey) and its 16px extent.
    task automatic check_spr(input string tag, input int i, input int ex, input int ey);
        step();
        probe({tag, "_in"},    i, ex,      ey,      1);
        probe({tag, "_left"},  i, ex - 1,  ey,      0);
        probe({tag, "_above"}, i, ex,      ey - 1,  0);
        probe({tag, "_far"},   i, ex + 15, ey + 15, 1);
        probe({tag, "_right"}, i, ex + 16, ey + 15, 0);
        probe({tag, "_below"}, i, ex + 15, ey + 16, 0);
    endtask

    task automatic do_frame(input bit expect_fd);
        int first, cnt;
        first = 0;
        cnt   = 0;
        x = 10'd0;
        y = 10'd480;
        step();
        y = 10'd0;
        for (int k = 1; k <= 6; k++) begin
            if (frame_done === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
            end
            step();
        end
        chk("fd_cycle", first, expect_fd ? 3 : 0);
        chk("fd_count", cnt, expect_fd ? 1 : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        x = 10'd100;
        y = 10'd100;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int fd_seen;
        rst_n = 1'b0;
        pause = 1'b0;
        sp_x  = 4'd1;
        sp_y  = 4'd1;
        x     = 10'd100;
        y     = 10'd100;

        // Reset state
        do_reset();
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_draw_away", int'(b_draw), 0);
`ifdef BOUNCE_COUNT_EN
        chk("rst_hit_cnt", int'(hit_cnt), 0);
`endif
        check_spr("rst_s0", 0, 220, 190);
        check_spr("rst_s1", 1, 236, 198);

        // Box edges
        x = 10'd220; y = 10'd190; #1; chk("sq_tl", int'(b_square), 1);
        x = 10'd219; y = 10'd190; #1; chk("sq_left", int'(b_square), 0);
        x = 10'd419; y = 10'd289; #1; chk("sq_br", int'(b_square), 1);
        x = 10'd420; y = 10'd289; #1; chk("sq_right", int'(b_square), 0);
        x = 10'd419; y = 10'd290; #1; chk("sq_below", int'(b_square), 0);

        // Straight motion, 10 frames at 1px
        for (int f = 0; f < 10; f++) do_frame(1'b1);
        check_spr("lin_s0", 0, 230, 200);
        check_spr("lin_s1", 1, 246, 208);

        // Right wall clamp, Y frozen
        do_reset();
        sp_x = 4'd15;
        sp_y = 4'd0;
        for (int f = 0; f < 12; f++) do_frame(1'b1);
        check_spr("rw12_s0", 0, 400, 190);
        check_spr("rw12_s1", 1, 404, 198);
`ifdef BOUNCE_COUNT_EN
        chk("rw12_hits", int'(hit_cnt), 1);
`endif
        do_frame(1'b1);
        check_spr("rw13_s0", 0, 404, 190);
        check_spr("rw13_s1", 1, 389, 198);
`ifdef BOUNCE_COUNT_EN
        chk("rw13_hits", int'(hit_cnt), 2);
`endif
        do_frame(1'b1);
        check_spr("rw14_s0", 0, 389, 190);

        // Corner: sprite 0 hits X and Y walls on frame 13
        do_reset();
        sp_x = 4'd15;
        sp_y = 4'd7;
        for (int f = 0; f < 13; f++) do_frame(1'b1);
        check_spr("cor13_s0", 0, 404, 274);
        check_spr("cor13_s1", 1, 389, 260);
`ifdef BOUNCE_COUNT_EN
        chk("cor13_hits", int'(hit_cnt), 3);
`endif
        do_frame(1'b1);
        check_spr("cor14_s0", 0, 389, 267);
        check_spr("cor14_s1", 1, 374, 253);

        // Pause across 5 ticks, then resume
        pause = 1'b1;
        for (int f = 0; f < 5; f++) do_frame(1'b0);
        check_spr("pau_s0", 0, 389, 267);
        check_spr("pau_s1", 1, 374, 253);
        pause = 1'b0;
        do_frame(1'b1);
        check_spr("res_s0", 0, 374, 260);
        check_spr("res_s1", 1, 359, 246);
`ifdef BOUNCE_COUNT_EN
        chk("res_hits", int'(hit_cnt), 3);
`endif

        // Reset on cycle tick+1
        fd_seen = 0;
        x = 10'd0;
        y = 10'd480;
        step();
        rst_n = 1'b0;
        y = 10'd0;
        if (frame_done === 1'b1) fd_seen++;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (frame_done === 1'b1) fd_seen++;
            step();
        end
        chk("mid_rst_fd", fd_seen, 0);
        check_spr("mid_rst_s0", 0, 220, 190);
        check_spr("mid_rst_s1", 1, 236, 198);
`ifdef BOUNCE_COUNT_EN
        chk("mid_rst_hits", int'(hit_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
